// File: rtl/data_cail_mc.sv
`timescale 1ns/1ps
// Multi-channel int16 -> float32 calibration: per-channel gain table, frame counting, ch/last tags.
// Latency 1+CVT_LAT+MUL_LAT cycles, one sample per cycle, no backpressure (in_valid outside RUN is dropped).
module data_cail_mc #(
  parameter int CH_NUM  = 8,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 16,
  parameter int CVT_LAT = 6,
  parameter int MUL_LAT = 5,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              scale_en,
  input  logic              param_we,
  input  logic [CH_W-1:0]   param_addr,
  input  logic [31:0]       param_wdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int LAT  = 1 + CVT_LAT + MUL_LAT;
  localparam int DC_W = $clog2(LAT + 1);
  localparam logic [31:0] ONE_F = 32'h3F80_0000;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_q, cnt_q, cnt_nxt;
  logic [CH_W-1:0]   chan_q;
  logic [DC_W-1:0]   dcnt_q;
  logic              accept, last_acc, drain_end;
  logic [31:0]       tbl_q [CH_NUM];
  logic [31:0]       gain_sel;

  logic [DATA_W-1:0] s0_data_q;
  logic [31:0]       s0_gain_q;
  logic [31:0]       cvt_q [CVT_LAT];
  logic [31:0]       gdl_q [CVT_LAT];
  logic [31:0]       mul_q [MUL_LAT];
  logic              vld_q [LAT];
  logic [CH_W-1:0]   chp_q [LAT];
  logic              lst_q [LAT];

  // Exact for any DATA_W up to 24: the magnitude fits the 24-bit significand.
  function automatic logic [31:0] i2f(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] mag;
    logic [DATA_W+23:0] sh;
    int p;
    mag = d[DATA_W-1] ? (~d + 1'b1) : d;
    p = 0;
    for (int i = 0; i < DATA_W; i++) begin
      if (mag[i]) p = i;
    end
    sh = {24'b0, mag} << (23 - p);
    i2f = (mag == '0) ? 32'h0 : {d[DATA_W-1], 8'(127 + p), sh[22:0]};
  endfunction

  // Round-to-nearest-even; denormals flush to zero, overflow goes to infinity.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s, g, st, a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea, eb;
    logic [47:0] prod;
    logic [22:0] m;
    logic [23:0] mr;
    int          ex;
    s     = a[31] ^ b[31];
    ea    = a[30:23];
    eb    = b[30:23];
    a_nan = (ea == 8'hFF) && (a[22:0] != '0);
    b_nan = (eb == 8'hFF) && (b[22:0] != '0);
    a_inf = (ea == 8'hFF) && (a[22:0] == '0);
    b_inf = (eb == 8'hFF) && (b[22:0] == '0);
    prod  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ex    = int'(ea) + int'(eb) - 127;
    if (prod[47]) begin
      m  = prod[46:24];
      g  = prod[23];
      st = |prod[22:0];
      ex = ex + 1;
    end else begin
      m  = prod[45:23];
      g  = prod[22];
      st = |prod[21:0];
    end
    mr = {1'b0, m} + 24'(g && (st || m[0]));
    if (mr[23]) ex = ex + 1;
    if (a_nan || b_nan)                         fmul = 32'h7FC0_0000;
    else if ((a_inf && eb == '0) || (b_inf && ea == '0)) fmul = 32'h7FC0_0000;
    else if (a_inf || b_inf)                    fmul = {s, 8'hFF, 23'b0};
    else if (ea == '0 || eb == '0)              fmul = {s, 31'b0};
    else if (ex >= 255)                         fmul = {s, 8'hFF, 23'b0};
    else if (ex <= 0)                           fmul = {s, 31'b0};
    else                                        fmul = {s, 8'(ex), mr[22:0]};
  endfunction

  assign accept    = (state_q == RUN) && in_valid;
  assign cnt_nxt   = cnt_q + 1'b1;
  assign last_acc  = accept && (cnt_nxt == len_q);
  assign drain_end = (state_q == DRAIN) && (dcnt_q == DC_W'(LAT - 1));
  assign gain_sel  = scale_en ? tbl_q[chan_q] : ONE_F;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && frame_len != '0) state_d = RUN;
      RUN:     if (last_acc) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done_d = drain_end || ((state_q == IDLE) && start && (frame_len == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      chan_q <= '0;
      dcnt_q <= '0;
      for (int i = 0; i < CH_NUM; i++) tbl_q[i] <= ONE_F;
    end else begin
      if ((state_q == IDLE) && start) begin
        len_q  <= frame_len;
        cnt_q  <= '0;
        chan_q <= '0;
      end else if (accept) begin
        cnt_q  <= cnt_nxt;
        chan_q <= (chan_q == CH_W'(CH_NUM - 1)) ? '0 : chan_q + 1'b1;
      end
      dcnt_q <= (state_q == DRAIN) ? dcnt_q + 1'b1 : '0;
      for (int i = 0; i < CH_NUM; i++) begin
        if (param_we && (param_addr == CH_W'(i))) tbl_q[i] <= param_wdata;
      end
    end
  end

  // Data stages run freely; the valid pipeline alone decides what is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_data_q <= '0;
      s0_gain_q <= '0;
      for (int k = 0; k < CVT_LAT; k++) begin
        cvt_q[k] <= '0;
        gdl_q[k] <= '0;
      end
      for (int k = 0; k < MUL_LAT; k++) mul_q[k] <= '0;
      for (int k = 0; k < LAT; k++) begin
        vld_q[k] <= 1'b0;
        chp_q[k] <= '0;
        lst_q[k] <= 1'b0;
      end
    end else begin
      s0_data_q <= in_data;
      s0_gain_q <= gain_sel;
      cvt_q[0]  <= i2f(s0_data_q);
      gdl_q[0]  <= s0_gain_q;
      for (int k = 1; k < CVT_LAT; k++) begin
        cvt_q[k] <= cvt_q[k-1];
        gdl_q[k] <= gdl_q[k-1];
      end
      if (MUL_LAT > 1 || vld_q[LAT-2]) mul_q[0] <= fmul(cvt_q[CVT_LAT-1], gdl_q[CVT_LAT-1]);
      for (int k = 1; k < MUL_LAT; k++) begin
        if (k < MUL_LAT - 1 || vld_q[LAT-2]) mul_q[k] <= mul_q[k-1];
      end
      vld_q[0] <= accept;
      chp_q[0] <= chan_q;
      lst_q[0] <= last_acc;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        chp_q[k] <= chp_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = mul_q[MUL_LAT-1];
  assign out_ch    = chp_q[LAT-1];
  assign out_last  = lst_q[LAT-1];
  assign done      = done_q;

endmodule

// File: tb/tb_data_cail_mc.sv
`timescale 1ns/1ps
// Directed bench for data_cail_mc: vector table per frame plus hand sequences for the timing corners.
module tb_data_cail_mc;

  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, scale_en, param_we;
  logic [15:0] frame_len, in_data;
  logic [2:0]  param_addr;
  logic [31:0] param_wdata;
  logic        out_valid, out_last, busy, done;
  logic [31:0] out_data;
  logic [2:0]  out_ch;

  always #5 clk = ~clk;

  data_cail_mc dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .scale_en(scale_en),
    .param_we(param_we), .param_addr(param_addr), .param_wdata(param_wdata),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct { logic [15:0] d; logic se; logic [31:0] exp; } vec_t;
  typedef struct { logic [31:0] d; logic [2:0] ch; logic last; int acc; } exp_t;

  vec_t vecs [64];
  exp_t exp_q [$];
  int errors = 0, checks = 0, cyc = 0, n_out = 0, done_cnt = 0, last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      exp_t e;
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ch", 32'(out_ch), 32'(e.ch));
        chk("out_last", 32'(out_last), 32'(e.last));
        chk("latency", 32'(cyc - e.acc), 32'(LAT));
      end
    end else if (out_last !== 1'b0) begin
      chk("stray_out_last", 32'(out_last), 32'd0);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic se, input logic [31:0] ed,
                      input logic [2:0] ch, input logic last, input bit acc);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    scale_en = se;
    if (acc) begin
      e.d = ed; e.ch = ch; e.last = last; e.acc = cyc;
      exp_q.push_back(e);
      last_acc = cyc;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    frame_len = 16'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wr_param(input logic [2:0] a, input logic [31:0] v);
    param_we = 1'b1; param_addr = a; param_wdata = v;
    tick();
    param_we = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && done !== 1'b1; k++) tick();
    if (done !== 1'b1) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_cycle", 32'(cyc - last_acc), 32'(LAT + 1));
      chk("busy_falls_with_done", 32'(busy), 32'd0);
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic run_frame(input int first, input int n, input int gap);
    int n0;
    n0 = n_out;
    do_start(n);
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      send(vecs[first+i].d, vecs[first+i].se, vecs[first+i].exp, 3'(i % 8), i == n - 1, 1'b1);
      repeat (gap) tick();
    end
    wait_done();
    chk("frame_out_count", 32'(n_out - n0), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n0, d0;
    rst = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
    scale_en = 1'b1; param_we = 1'b0; param_addr = '0; param_wdata = '0;

    vecs[0] = '{16'h0001, 1'b1, 32'h3F80_0000};
    vecs[1] = '{16'h8000, 1'b1, 32'hC700_0000};
    vecs[2] = '{16'h7FFF, 1'b1, 32'h46FF_FE00};
    for (int i = 0; i < 16; i++) begin
      vecs[3+i]  = '{16'h03E8, 1'b1, (i % 8 == 1) ? 32'h44FA_0000 : 32'h447A_0000};
      vecs[19+i] = '{16'h03E8, 1'b0, 32'h447A_0000};
    end
    vecs[35] = '{16'hFFFF, 1'b0, 32'hBF80_0000};
    vecs[36] = '{16'h0100, 1'b0, 32'h4380_0000};
    vecs[37] = '{16'hFC18, 1'b0, 32'hC47A_0000};

    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Unity gain, extremes of the signed range
    run_frame(0, 3, 0);

    // Channel 1 gain 2.0 over two interleave passes, then gain bypass
    wr_param(3'd1, 32'h4000_0000);
    run_frame(3, 16, 0);
    run_frame(19, 16, 0);

    // Table write to ch 0 in the same cycle a ch 0 sample is accepted
    do_start(9);
    param_we = 1'b1; param_addr = 3'd0; param_wdata = 32'h4000_0000;
    send(16'h03E8, 1'b1, 32'h447A_0000, 3'd0, 1'b0, 1'b1);
    param_we = 1'b0;
    for (int i = 1; i < 9; i++)
      send(16'h03E8, 1'b1, (i == 1 || i == 8) ? 32'h44FA_0000 : 32'h447A_0000, 3'(i % 8), i == 8, 1'b1);
    wait_done();

    // Zero-length frame
    n0 = n_out; d0 = done_cnt;
    start = 1'b1; frame_len = '0;
    tick();
    start = 1'b0;
    chk("zero_len_done", 32'(done), 32'd1);
    chk("zero_len_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_len_done_drop", 32'(done), 32'd0);
    repeat (15) tick();
    chk("zero_len_no_out", 32'(n_out - n0), 32'd0);
    chk("zero_len_done_count", 32'(done_cnt - d0), 32'd1);

    // in_valid in IDLE and DRAIN, second start mid-RUN
    n0 = n_out;
    repeat (3) send(16'h7FFF, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    do_start(4);
    send(16'h0001, 1'b0, 32'h3F80_0000, 3'd0, 1'b0, 1'b1);
    send(16'h0001, 1'b0, 32'h3F80_0000, 3'd1, 1'b0, 1'b1);
    start = 1'b1; frame_len = 16'd2;
    send(16'h0001, 1'b0, 32'h3F80_0000, 3'd2, 1'b0, 1'b1);
    start = 1'b0;
    send(16'h0001, 1'b0, 32'h3F80_0000, 3'd3, 1'b1, 1'b1);
    repeat (3) send(16'h7FFF, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    wait_done();
    chk("ignored_out_count", 32'(n_out - n0), 32'd4);

    // Gapped input, one sample every third cycle
    run_frame(35, 3, 2);

    // Reset in the middle of a 20-sample frame
    wr_param(3'd0, 32'h4000_0000);
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      if (i == 16) begin
        chk("fifth_out_valid", 32'(out_valid), 32'd1);
        chk("fifth_out_ch", 32'(out_ch), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        break;
      end
      send(16'h03E8, 1'b1, (i % 8 < 2) ? 32'h44FA_0000 : 32'h447A_0000, 3'(i % 8), i == 19, 1'b1);
    end
    exp_q.delete();
    n0 = n_out; d0 = done_cnt;
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("post_rst_no_out", 32'(n_out - n0), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    n0 = n_out;
    do_start(1);
    send(16'h0001, 1'b1, 32'h3F80_0000, 3'd0, 1'b1, 1'b1);
    wait_done();
    chk("post_rst_out_count", 32'(n_out - n0), 32'd1);

    chk("missing_outputs", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_cail_mc.md
# data_cail_mc

Multi-channel calibration engine for the AD7606 capture path. Each 16-bit signed ADC sample is converted to IEEE-754 single precision and multiplied by a per-channel 32-bit float gain from an internal coefficient table. Samples are accepted as a counted frame, in interleaved channel order, and results are emitted with channel index and frame-last tags. It sits between the AD7606 sample collector and the float result FIFO/uplink, and supersedes the single-channel fixed-window calibrator.

## Interface
- `CH_NUM`, 8 — channels per interleave cycle, 1..16.
- `DATA_W`, 16 — sample width, signed two's complement.
- `LEN_W`, 16 — width of the frame length.
- `CVT_LAT`, 6 — latency of the `short_to_float` IP instance, in cycles.
- `MUL_LAT`, 5 — latency of the `mult` IP instance, in cycles.
- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — one-cycle pulse that begins a frame; sampled only in IDLE.
- `frame_len` in LEN_W — total samples in the frame, across all channels; latched on `start`.
- `in_valid` in 1 — sample strobe.
- `in_data` in DATA_W — sample value.
- `scale_en` in 1 — 1 applies the table gain; 0 uses a gain of 1.0 (0x3F800000). Sampled per sample.
- `param_we` in 1 — coefficient table write strobe.
- `param_addr` in clog2(CH_NUM) — table index.
- `param_wdata` in 32 — float gain to write.
- `out_valid` out 1 — result strobe.
- `out_data` out 32 — calibrated float result.
- `out_ch` out clog2(CH_NUM) — channel index of the result.
- `out_last` out 1 — marks the final sample of the frame.
- `busy` out 1 — high in RUN and DRAIN.
- `done` out 1 — one-cycle pulse when the frame is fully emitted.

## Operation
- States and transitions:
  - IDLE -> RUN on `start` when `frame_len` is nonzero.
  - `start` with `frame_len` = 0 stays in IDLE and pulses `done` on the next cycle, with no outputs.
  - RUN -> DRAIN in the cycle the `frame_len`-th sample is accepted.
  - DRAIN -> IDLE after LAT = 1+CVT_LAT+MUL_LAT cycles; `done` pulses on the same edge that enters IDLE.
- Sample acceptance: `in_valid` is accepted only in RUN. In IDLE and DRAIN it is ignored; no output and no counter change.
- `start` in RUN or DRAIN is ignored.
- Channel counter:
  - Resets to 0 at each `start`.
  - Increments per accepted sample and wraps from CH_NUM-1 to 0.
  - It is the `out_ch` tag carried with the sample.
- Sample counter: counts accepted samples. The sample that makes count equal `frame_len` is tagged last.
- Pipeline:
  - Stage 0 registers `in_data`, the valid bit, the channel, the last flag and the selected gain.
  - The gain is read from the table at acceptance, or is 1.0 when `scale_en`=0.
  - The gain rides a CVT_LAT-deep delay line so it meets the converter output at the multiplier input.
  - Valid, channel and last ride a LAT-deep shift register aligned with `out_data`.
- Coefficient table:
  - CH_NUM×32 registers, all reset to 1.0 (0x3F800000).
  - Writes are allowed in any state and land on the clock edge.
  - A sample accepted in the same cycle as a write to its channel uses the old value; later samples use the new value.
  - `param_addr` >= CH_NUM is ignored.
- Arithmetic:
  - `in_data` is sign-interpreted; -32768..32767 converts exactly.
  - Rounding, NaN and denormal handling are those of the IP cores; no extra saturation.
- `out_data` holds its last value when `out_valid`=0.

## Timing
- Latency from an accepted `in_valid` to `out_valid` is LAT cycles; LAT=12 at the defaults.
- Throughput is one sample per cycle; back-to-back `in_valid` is allowed, with no backpressure.
- `out_last` is high only together with the final `out_valid`.
- `done` is asserted one cycle after `out_last`, because DRAIN spans LAT cycles from the last accept.
- `busy` rises the cycle after `start` and falls with `done`.
- Reset values: `out_valid`, `out_last`, `busy`, `done` = 0; `out_data` = 0; `out_ch` = 0.
- Reset values: state = IDLE; counters = 0; shift registers cleared; table = 1.0.
- `rst` mid-frame aborts immediately, with no `done` and no further `out_valid`. In-flight IP outputs are masked by the cleared valid pipeline.

## Test plan
- Unity gain, CH_NUM=8, frame_len=3, samples 0x0001, 0x8000, 0x7FFF:
  - Outputs 0x3F800000, 0xC7000000, 0x46FFFE00 on ch 0, 1, 2.
  - Each arrives 12 cycles after its input; `out_last` on the third; `done` one cycle later.
- Write 0x40000000 to ch 1, then a frame of 16 samples, all 0x03E8:
  - ch 1 outputs are 0x44FA0000 (both passes); all other channels are 0x447A0000.
  - `out_ch` wraps 7->0.
  - Repeat with `scale_en`=0: all outputs are 0x447A0000.
- Write ch 0 to 2.0 in the same cycle a ch 0 sample of 0x03E8 is accepted:
  - That result is 0x447A0000; the next ch 0 sample gives 0x44FA0000.
- `frame_len`=0 start: `done` pulses the next cycle, `busy` stays 0, no `out_valid`.
- Ignored inputs:
  - `in_valid` in IDLE and DRAIN, and a second `start` mid-RUN: output count equals `frame_len` exactly.
  - Gapped `in_valid` (1 of every 3 cycles): latency stays 12 per sample.
- Assert `rst` during the 5th output of a 20-sample frame:
  - `out_valid`, `busy`, `done` drop to 0 asynchronously.
  - Table reads back 1.0: a subsequent `frame_len`=1 frame with 0x0001 outputs 0x3F800000.
